// File: rtl/mfm_pkg.sv
// Shared widths, window geometry and the truncating shift used by the MFM data separator.
package mfm_pkg;

    localparam int DEF_CELL_CLKS = 10;

    function automatic int cnt_width(input int cells);
        return $clog2(cells);
    endfunction

    function automatic int err_width(input int cells);
        return $clog2(cells) + 1;
    endfunction

    function automatic int half_of(input int cells);
        return cells / 2;
    endfunction

    function automatic int clock_centre(input int cells);
        return half_of(cells) / 2;
    endfunction

    function automatic int data_centre(input int cells);
        return half_of(cells) + half_of(cells) / 2;
    endfunction

    // Arithmetic shift that rounds toward zero rather than toward minus infinity.
    function automatic int trunc_shift(input int err, input int shift);
        if (err < 0)
            return -((-err) >>> shift);
        return err >>> shift;
    endfunction

endpackage

// File: rtl/mfm_dpll_sep_edge_sync.sv
// Read-data synchroniser followed by a one-cycle rising-edge pulse generator.
module mfm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_50,
    input  logic reset,
    input  logic raw_mfm,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   last_q;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            sync   <= '0;
            last_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], raw_mfm};
            last_q <= sync[SYNC_STAGES-1];
            pulse  <= sync[SYNC_STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/mfm_dpll_sep.sv
// Proportional-gain DPLL data separator: tracks bit-cell phase from flux pulses and
// emits one decoded MFM data bit per cell with clock-bit, violation and lock status.
module mfm_dpll_sep
    import mfm_pkg::*;
#(
    parameter int CELL_CLKS     = DEF_CELL_CLKS,
    parameter int GAIN_SHIFT    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int LOCK_TOL      = 1,
    parameter int LOCK_COUNT    = 8,
    parameter int MAX_GAP_CELLS = 3
) (
    input  logic                       clk_50,
    input  logic                       reset,
    input  logic                       raw_mfm,
    output logic                       cell_clk,
    output logic                       data_window,
    output logic                       data_bit,
    output logic                       clock_bit,
    output logic                       bit_valid,
    output logic                       clock_violation,
    output logic                       locked,
    output logic [$clog2(CELL_CLKS):0] phase_err
);

    localparam int CW   = cnt_width(CELL_CLKS);
    localparam int EW   = err_width(CELL_CLKS);
    localparam int HALF = half_of(CELL_CLKS);
    localparam int CC   = clock_centre(CELL_CLKS);
    localparam int CD   = data_centre(CELL_CLKS);
    localparam int LW   = $clog2(LOCK_COUNT + 1);
    localparam int GW   = $clog2(MAX_GAP_CELLS + 2);

    logic          pulse;
    logic [CW-1:0] cnt;
    logic          cp;
    logic          dp;
    logic          prev_data;
    logic [LW-1:0] lock_cnt;
    logic [GW-1:0] gap_cnt;

    int   cnt_i;
    int   err_i;
    int   corr_i;
    int   next_i;
    int   lock_i;
    int   gap_i;
    logic in_clk;
    logic in_tol;
    logic cell_end;
    logic cp_new;
    logic dp_new;

    mfm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_50 (clk_50),
        .reset  (reset),
        .raw_mfm(raw_mfm),
        .pulse  (pulse)
    );

    assign cell_clk    = (int'(cnt) < HALF);
    assign data_window = ~cell_clk;

    // Phase error is measured against the centre of whichever window the pulse fell in.
    always_comb begin
        cnt_i    = int'(cnt);
        in_clk   = (cnt_i < HALF);
        err_i    = cnt_i - (in_clk ? CC : CD);
        corr_i   = pulse ? trunc_shift(err_i, GAIN_SHIFT) : 0;
        next_i   = cnt_i + 1 - corr_i;
        cell_end = (next_i == CELL_CLKS);
        cp_new   = cp | (pulse & in_clk);
        dp_new   = dp | (pulse & ~in_clk);
        in_tol   = (((err_i < 0) ? -err_i : err_i) <= LOCK_TOL);
        lock_i   = int'(lock_cnt);
        gap_i    = int'(gap_cnt);
        if (pulse) begin
            gap_i = 0;
            if (in_tol)
                lock_i = (lock_i + 1 > LOCK_COUNT) ? LOCK_COUNT : lock_i + 1;
            else
                lock_i = 0;
        end else if (cell_end && !cp_new && !dp_new) begin
            if (gap_i <= MAX_GAP_CELLS)
                gap_i = gap_i + 1;
            if (gap_i > MAX_GAP_CELLS)
                lock_i = 0;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            cnt             <= '0;
            cp              <= 1'b0;
            dp              <= 1'b0;
            prev_data       <= 1'b0;
            lock_cnt        <= '0;
            gap_cnt         <= '0;
            locked          <= 1'b0;
            phase_err       <= '0;
            bit_valid       <= 1'b0;
            data_bit        <= 1'b0;
            clock_bit       <= 1'b0;
            clock_violation <= 1'b0;
        end else begin
            cnt       <= cell_end ? '0 : next_i[CW-1:0];
            bit_valid <= cell_end;
            lock_cnt  <= lock_i[LW-1:0];
            gap_cnt   <= gap_i[GW-1:0];
            locked    <= (lock_i == LOCK_COUNT);
            if (pulse)
                phase_err <= err_i[EW-1:0];
            // A pulse in the closing cycle still belongs to the cell being closed.
            if (cell_end) begin
                data_bit        <= dp_new;
                clock_bit       <= cp_new;
                clock_violation <= (cp_new != (!prev_data && !dp_new));
                prev_data       <= dp_new;
                cp              <= 1'b0;
                dp              <= 1'b0;
            end else begin
                cp <= cp_new;
                dp <= dp_new;
            end
        end
    end

endmodule

// File: tb/tb_mfm_dpll_sep.sv
// Randomised flux-stream bench for mfm_dpll_sep against a cell-level reference model,
// plus a directed snap-to-centre case on a CELL_CLKS=16, GAIN_SHIFT=0 instance.
module tb_mfm_dpll_sep;

    localparam int CELL    = 10;
    localparam int SHIFT   = 1;
    localparam int STAGES  = 2;
    localparam int TOL     = 1;
    localparam int NEED    = 8;
    localparam int GAP_MAX = 3;
    localparam int HALF    = CELL / 2;
    localparam int CC      = HALF / 2;
    localparam int CD      = HALF + HALF / 2;
    localparam int CELL16  = 16;
    localparam int CC16    = (CELL16 / 2) / 2;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b1;
    logic       raw_mfm = 1'b0;
    logic       cell_clk, data_window, data_bit, clock_bit, bit_valid, clock_violation, locked;
    logic [4:0] phase_err;

    logic       reset16 = 1'b1;
    logic       raw16 = 1'b0;
    logic       cc16, dw16, db16, cb16, bv16, viol16, lk16;
    logic [4:0] phase_err16;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int m_cnt, m_cp, m_dp, m_prev, m_lock, m_gap;
    int e_valid, e_data, e_clock, e_viol, e_locked, e_perr;
    bit raw_hist[$];

    always #5 clk_50 = ~clk_50;

    mfm_dpll_sep dut (
        .clk_50(clk_50), .reset(reset), .raw_mfm(raw_mfm),
        .cell_clk(cell_clk), .data_window(data_window), .data_bit(data_bit),
        .clock_bit(clock_bit), .bit_valid(bit_valid), .clock_violation(clock_violation),
        .locked(locked), .phase_err(phase_err)
    );

    mfm_dpll_sep #(.CELL_CLKS(CELL16), .GAIN_SHIFT(0)) dut16 (
        .clk_50(clk_50), .reset(reset16), .raw_mfm(raw16),
        .cell_clk(cc16), .data_window(dw16), .data_bit(db16),
        .clock_bit(cb16), .bit_valid(bv16), .clock_violation(viol16),
        .locked(lk16), .phase_err(phase_err16)
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        raw_hist.delete();
        for (int i = 0; i < STAGES + 2; i++) raw_hist.push_back(1'b0);
        m_cnt = 0; m_cp = 0; m_dp = 0; m_prev = 0; m_lock = 0; m_gap = 0;
        e_valid = 0; e_data = 0; e_clock = 0; e_viol = 0; e_locked = 0; e_perr = 0;
    endtask

    // One clock of the reference: a transition reaches the PLL STAGES+1 edges after it is sampled.
    task automatic modelStep(input bit rst, input bit raw);
        bit seen;
        int err, corr, step;
        if (rst) begin
            modelReset();
            return;
        end
        seen = raw_hist[STAGES] && !raw_hist[STAGES + 1];
        raw_hist.push_front(raw);
        void'(raw_hist.pop_back());
        err  = m_cnt - ((m_cnt < HALF) ? CC : CD);
        step = 1;
        if (seen) begin
            corr   = err / (1 << SHIFT);
            step   = 1 - corr;
            e_perr = err;
            if (m_cnt < HALF) m_cp = 1; else m_dp = 1;
            m_gap = 0;
            if (err <= TOL && err >= -TOL) m_lock = (m_lock < NEED) ? m_lock + 1 : NEED;
            else m_lock = 0;
        end
        m_cnt = m_cnt + step;
        e_valid = 0;
        if (m_cnt == CELL) begin
            e_valid = 1;
            e_data  = m_dp;
            e_clock = m_cp;
            e_viol  = (m_cp != ((m_prev == 0 && m_dp == 0) ? 1 : 0)) ? 1 : 0;
            m_prev  = m_dp;
            if (m_cp == 0 && m_dp == 0) begin
                m_gap++;
                if (m_gap > GAP_MAX) m_lock = 0;
            end
            m_cp = 0; m_dp = 0; m_cnt = 0;
        end
        e_locked = (m_lock == NEED) ? 1 : 0;
    endtask

    task automatic scoreCycle();
        checkOutput("cell_clk", cell_clk, (m_cnt < HALF) ? 1 : 0);
        checkOutput("data_window", data_window, (m_cnt < HALF) ? 0 : 1);
        checkOutput("bit_valid", bit_valid, e_valid);
        checkOutput("locked", locked, e_locked);
        checkOutput("phase_err", $signed(phase_err), e_perr);
        if (e_valid != 0) begin
            checkOutput("data_bit", data_bit, e_data);
            checkOutput("clock_bit", clock_bit, e_clock);
            checkOutput("clock_violation", clock_violation, e_viol);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit raw);
        reset   = rst;
        raw_mfm = raw;
        @(posedge clk_50);
        modelStep(rst, raw);
        cyc = rst ? 0 : cyc + 1;
        @(negedge clk_50);
        scoreCycle();
    endtask

    task automatic driveFlux(input int len);
        applyStimulus(1'b0, 1'b1);
        repeat (len - 1) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        int len;
        int sel;
        bit found;

        // Snap-to-centre case: pulse consumed at cnt=6 must restart the count at Cc+1.
        @(posedge clk_50);
        @(negedge clk_50);
        reset16 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            raw16 = (k == 4);
            @(posedge clk_50);
            @(negedge clk_50);
            if (k == 7) begin
                checkOutput("c16_phase_err", $signed(phase_err16), 2);
                checkOutput("c16_cell_clk", cc16, 1);
                checkOutput("c16_locked", lk16, 0);
            end
            if (k < 7 + CELL16 - (CC16 + 1))
                checkOutput("c16_no_valid", bv16, 0);
            if (k == 7 + CELL16 - (CC16 + 1)) begin
                checkOutput("c16_valid", bv16, 1);
                checkOutput("c16_data_bit", db16, 0);
                checkOutput("c16_clock_bit", cb16, 1);
                checkOutput("c16_violation", viol16, 0);
            end
        end
        reset16 = 1'b1;

        modelReset();
        repeat (3) applyStimulus(1'b1, 1'b0);
        checkOutput("rst_cell_clk", cell_clk, 1);
        checkOutput("rst_data_window", data_window, 0);
        checkOutput("rst_bit_valid", bit_valid, 0);
        checkOutput("rst_data_bit", data_bit, 0);
        checkOutput("rst_clock_bit", clock_bit, 0);
        checkOutput("rst_violation", clock_violation, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_phase_err", $signed(phase_err), 0);

        // All-zero data: one clock pulse per cell, each consumed at cnt=Cc.
        repeat (CELL - 1) applyStimulus(1'b0, 1'b0);
        for (int p = 1; p <= 12; p++) begin
            applyStimulus(1'b0, 1'b1);
            for (int k = 1; k < CELL; k++) begin
                applyStimulus(1'b0, 1'b0);
                if (cyc == CELL * NEED + STAGES) checkOutput("lock_before_8th", locked, 0);
                if (cyc == CELL * NEED + STAGES + 1) checkOutput("lock_after_8th", locked, 1);
            end
        end

        repeat (5 * CELL) applyStimulus(1'b0, 1'b0);
        checkOutput("gap_unlock", locked, 0);

        // A1 sync mark intervals with the missing clock, repeated.
        for (int r = 0; r < 3; r++) begin
            driveFlux(20); driveFlux(15); driveFlux(20); driveFlux(15);
        end

        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 3) len = 10;
            else if (sel < 6) len = 15;
            else if (sel < 8) len = 20;
            else if (sel == 8) len = int'($urandom_range(35, 60));
            else len = 9 + int'($urandom_range(0, 13));
            len = len + int'($urandom_range(0, 2)) - 1;
            driveFlux(len);
            if (n == 120) applyStimulus(1'b1, 1'b0);
        end

        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            applyStimulus(1'b0, (n % 15) == 0);
            if (m_cnt == 6) found = 1'b1;
        end
        checkOutput("midcell_reset_reached", found, 1);
        if (found) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("midrst_cell_clk", cell_clk, 1);
            checkOutput("midrst_bit_valid", bit_valid, 0);
            checkOutput("midrst_locked", locked, 0);
            repeat (CELL) applyStimulus(1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
